// File: rtl/sram_like_mem_responder_if.sv
// Single-beat SRAM-like memory bus between the data cache (master) and its memory responder (slave).
interface sram_like_mem_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_mem_responder.sv
// One-outstanding SRAM-like responder: addr_ok after ADDR_WAIT held-req cycles, data_ok LAT cycles after the handshake.
// Requests are stalled by withholding addr_ok while busy; byte-masked writes commit on the data_ok edge.
module sram_like_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int ADDR_WAIT  = 1,
    parameter int LAT        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_like_mem_responder_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [7:0]              lat_cnt_q, lat_cnt_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic [1:0]              off_q, off_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    hs, done;
    logic [3:0]              strb;

    logic [31:0] mem [2**ADDR_WIDTH];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        wr_d       = wr_q;
        size_d     = size_q;
        off_d      = off_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        hs         = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.req) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == 8'(ADDR_WAIT)) begin
                    hs         = 1'b1;
                    wr_d       = bus.wr;
                    size_d     = bus.size;
                    off_d      = bus.addr[1:0];
                    idx_d      = bus.addr[ADDR_WIDTH+1:2];
                    wdata_d    = bus.wdata;
                    lat_cnt_d  = 8'(LAT - 1);
                    wait_cnt_d = '0;
                    state_d    = BUSY;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            BUSY: begin
                if (lat_cnt_q == 8'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            off_q      <= off_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        strb = 4'b1111;
        unique case (size_q)
            2'd0:    strb = 4'b0001 << off_q;
            2'd1:    strb = off_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // Array has no reset: a reset only abandons the pending write.
    always_ff @(posedge clk) begin
        if (done && !rst && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign bus.addr_ok = hs && !rst;
    assign bus.data_ok = done && !rst;
    assign bus.rdata   = (done && !rst && !wr_q) ? mem[idx_q] : 32'h0;
endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Bench for sram_like_mem_responder: three parameterisations, directed tables plus random traffic against a word model.
module tb_sram_like_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam int WAITS [3] = '{1, 3, 0};
    localparam int LATS  [3] = '{2, 4, 1};

    logic        req_d   [3];
    logic        wr_d    [3];
    logic [1:0]  size_d  [3];
    logic [31:0] addr_d  [3];
    logic [31:0] wdata_d [3];
    logic [31:0] rdata_w [3];
    logic        aok_w   [3];
    logic        dok_w   [3];

    sram_like_mem_responder_if bus0 ();
    sram_like_mem_responder_if bus1 ();
    sram_like_mem_responder_if bus2 ();

    assign bus0.req = req_d[0]; assign bus0.wr = wr_d[0]; assign bus0.size = size_d[0];
    assign bus0.addr = addr_d[0]; assign bus0.wdata = wdata_d[0];
    assign rdata_w[0] = bus0.rdata; assign aok_w[0] = bus0.addr_ok; assign dok_w[0] = bus0.data_ok;
    assign bus1.req = req_d[1]; assign bus1.wr = wr_d[1]; assign bus1.size = size_d[1];
    assign bus1.addr = addr_d[1]; assign bus1.wdata = wdata_d[1];
    assign rdata_w[1] = bus1.rdata; assign aok_w[1] = bus1.addr_ok; assign dok_w[1] = bus1.data_ok;
    assign bus2.req = req_d[2]; assign bus2.wr = wr_d[2]; assign bus2.size = size_d[2];
    assign bus2.addr = addr_d[2]; assign bus2.wdata = wdata_d[2];
    assign rdata_w[2] = bus2.rdata; assign aok_w[2] = bus2.addr_ok; assign dok_w[2] = bus2.data_ok;

    sram_like_mem_responder #(.ADDR_WIDTH(12), .ADDR_WAIT(1), .LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sram_like_mem_responder #(.ADDR_WIDTH(12), .ADDR_WAIT(3), .LAT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sram_like_mem_responder #(.ADDR_WIDTH(12), .ADDR_WAIT(0), .LAT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int  checks = 0;
    int  errors = 0;
    time hs_t [3];
    logic [31:0] mdl [int];

    typedef struct {
        bit          w;
        bit [1:0]    sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int key(input int d, input logic [31:0] a);
        return d * 65536 + int'((a >> 2) % 4096);
    endfunction

    // Reference: n-byte access covers the naturally aligned n-byte group containing addr.
    task automatic model_write(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n, off, k;
        logic [31:0] w;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        off = off - (off % n);
        k   = key(d, a);
        w   = mdl.exists(k) ? mdl[k] : 32'h0;
        for (int b = off; b < off + n; b++) w[8*b +: 8] = wd[8*b +: 8];
        mdl[k] = w;
    endtask

    // Entered just after a rising edge with DUT idle; leaves just after the edge ending data_ok.
    task automatic do_txn(input int d, input bit w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_wait, output logic [31:0] rd);
        int k;
        int nz;
        bit got;
        req_d[d] = 1'b1; wr_d[d] = w; size_d[d] = sz; addr_d[d] = a; wdata_d[d] = wd;
        rd = 32'h0; k = 0; got = 0;
        while (k <= 300 && !got) begin
            @(negedge clk);
            if (aok_w[d]) begin
                got = 1; hs_t[d] = $time;
            end else begin
                k++; @(posedge clk); #1;
            end
        end
        check("accept_wait", got ? 32'(k) : 32'hFFFFFFFF, 32'(exp_wait));
        if (got) begin
            @(posedge clk); #1;
            req_d[d] = 1'b0; wr_d[d] = 1'($urandom); size_d[d] = 2'($urandom);
            addr_d[d] = $urandom; wdata_d[d] = $urandom;
            k = 1; got = 0; nz = 0;
            while (k <= 300 && !got) begin
                @(negedge clk);
                if (aok_w[d]) nz++;
                if (dok_w[d]) begin
                    got = 1; rd = rdata_w[d];
                end else begin
                    if (rdata_w[d] != 32'h0) nz++;
                    k++; @(posedge clk); #1;
                end
            end
            check("data_latency", got ? 32'(k) : 32'hFFFFFFFF, 32'(LATS[d]));
            check("busy_quiet", 32'(nz), 32'd0);
            if (w) check("rdata_on_write", rd, 32'h0);
            @(posedge clk); #1;
        end
        req_d[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        time t0;
        int  nd;
        bit  got;
        for (int d = 0; d < 3; d++) begin
            req_d[d] = 1'b0; wr_d[d] = 1'b0; size_d[d] = 2'd0; addr_d[d] = 32'h0; wdata_d[d] = 32'h0;
        end
        rst = 1'b1;
        req_d[0] = 1'b1; wr_d[0] = 1'b1; size_d[0] = 2'd2; addr_d[0] = 32'h0; wdata_d[0] = 32'h12345678;

        // Reset held 3 cycles with req high: all outputs quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_addr_ok", 32'(aok_w[0]), 32'd0);
            check("rst_data_ok", 32'(dok_w[0]), 32'd0);
            check("rst_rdata", rdata_w[0], 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        do_txn(0, 1'b1, 2'd2, 32'h0, 32'h12345678, 1, rd);

        tbl[0]  = '{1'b1, 2'd2, 32'h10, 32'h11223344, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 32'h10, 32'h0,        32'h11223344};
        tbl[2]  = '{1'b1, 2'd0, 32'h13, 32'hAA000000, 32'h0};
        tbl[3]  = '{1'b1, 2'd1, 32'h10, 32'h0000BEEF, 32'h0};
        tbl[4]  = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hAA22BEEF};
        tbl[5]  = '{1'b1, 2'd2, 32'h14, 32'h00000000, 32'h0};
        tbl[6]  = '{1'b1, 2'd1, 32'h17, 32'h55667788, 32'h0};
        tbl[7]  = '{1'b0, 2'd2, 32'h14, 32'h0,        32'h55660000};
        tbl[8]  = '{1'b1, 2'd3, 32'h1B, 32'hDEADBEEF, 32'h0};
        tbl[9]  = '{1'b1, 2'd0, 32'h18, 32'h000000AB, 32'h0};
        tbl[10] = '{1'b0, 2'd2, 32'h18, 32'h0,        32'hDEADBEAB};
        tbl[11] = '{1'b1, 2'd0, 32'h1A, 32'h00770000, 32'h0};
        tbl[12] = '{1'b0, 2'd0, 32'h1A, 32'h0,        32'hDE77BEAB};
        for (int i = 0; i < 13; i++) begin
            do_txn(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, 1, rd);
            if (!tbl[i].w) check($sformatf("tbl_rd_%0d", i), rd, tbl[i].exp);
        end

        // Reset one cycle after a write handshake: no completion, memory keeps old word.
        req_d[0] = 1'b1; wr_d[0] = 1'b1; size_d[0] = 2'd2; addr_d[0] = 32'h0; wdata_d[0] = 32'hFFFFFFFF;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (aok_w[0]) got = 1;
            else begin @(posedge clk); #1; end
        end
        check("rstmid_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_d[0] = 1'b0; rst = 1'b1;
        nd = 0;
        @(negedge clk); if (dok_w[0]) nd++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); if (dok_w[0]) nd++;
            @(posedge clk); #1;
        end
        check("rstmid_no_data_ok", 32'(nd), 32'd0);
        do_txn(0, 1'b0, 2'd2, 32'h0, 32'h0, 1, rd);
        check("rstmid_old_word", rd, 32'h12345678);

        // ADDR_WAIT=3: two held cycles, drop, then the count restarts.
        req_d[1] = 1'b1; wr_d[1] = 1'b1; size_d[1] = 2'd2; addr_d[1] = 32'h20; wdata_d[1] = 32'h0;
        nd = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); if (aok_w[1]) nd++;
            @(posedge clk); #1;
        end
        req_d[1] = 1'b0;
        @(negedge clk); if (aok_w[1]) nd++;
        @(posedge clk); #1;
        check("wait3_early_accept", 32'(nd), 32'd0);
        do_txn(1, 1'b1, 2'd2, 32'h20, 32'h0BADF00D, 3, rd);
        model_write(1, 2'd2, 32'h20, 32'h0BADF00D);
        do_txn(1, 1'b0, 2'd2, 32'h20, 32'h0, 3, rd);
        check("wait3_read", rd, 32'h0BADF00D);

        // Aliasing and back-to-back spacing with ADDR_WAIT=0, LAT=1.
        do_txn(2, 1'b1, 2'd2, 32'h00004000, 32'hCAFEF00D, 0, rd);
        model_write(2, 2'd2, 32'h00004000, 32'hCAFEF00D);
        t0 = hs_t[2];
        do_txn(2, 1'b0, 2'd2, 32'h00000000, 32'h0, 0, rd);
        check("alias_read", rd, 32'hCAFEF00D);
        check("b2b_spacing", 32'(hs_t[2] - t0), 32'd20);

        // Random traffic against the word model, aliased addresses, random gaps.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] v;
                v = $urandom;
                do_txn(d, 1'b1, 2'd2, 32'(i * 4), v, WAITS[d], rd);
                model_write(d, 2'd2, 32'(i * 4), v);
            end
            for (int i = 0; i < 40; i++) begin
                bit          w;
                logic [1:0]  sz;
                logic [31:0] a, v;
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = ($urandom & 32'hFFFFC000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                v  = $urandom;
                for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
                do_txn(d, w, sz, a, v, WAITS[d], rd);
                if (w) model_write(d, sz, a, v);
                else   check("rand_read", rd, mdl[key(d, a)]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_like_mem_responder.md
# sram_like_mem_responder

Synthesizable responder for the single-beat SRAM-like bus that the data cache drives on its memory side: req/wr/size/addr/wdata in, rdata/addr_ok/data_ok out. It accepts one transaction at a time, applies a configurable address-phase stall and data latency, and services reads and byte-lane-masked writes from an internal word array. It stands in for the AXI bridge in cache-level benches and in small FPGA builds with on-chip data memory.

## Interface
- ADDR_WIDTH, 12, word-index bits; depth = 2^ADDR_WIDTH 32-bit words
- ADDR_WAIT, 1, cycles req must be held in IDLE before addr_ok (0..255)
- LAT, 2, cycles from address handshake edge to data_ok (1..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  transaction request, held until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 byte, 1 halfword, 2/3 word
- addr  in  32  byte address
- wdata  in  32  write data, already lane-positioned (byte at addr[1:0]=3 is wdata[31:24])
- rdata  out  32  full read word, valid only while data_ok=1 for a read, else 0
- addr_ok  out  1  address accepted this cycle (handshake = req & addr_ok)
- data_ok  out  1  one-cycle completion pulse

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; addr[31:ADDR_WIDTH+2] ignored (aliasing).
- FSM IDLE/BUSY. IDLE: wait_cnt counts cycles with req=1; addr_ok = req & (wait_cnt == ADDR_WAIT), combinational. req=0 in IDLE clears wait_cnt.
- On handshake edge: latch wr, size, addr, wdata; lat_cnt <= LAT-1; wait_cnt <= 0; go BUSY.
- BUSY: addr_ok=0; lat_cnt decrements each cycle; data_ok = (state==BUSY) & (lat_cnt==0); at that edge return to IDLE.
- Write strobe from latched size/addr: byte -> one lane per addr[1:0]; halfword -> 0011 if addr[1]=0 else 1100 (addr[0] ignored); word/size 3 -> 1111 (addr[1:0] ignored).
- Write commits, masked by strobe, at the rising edge ending the data_ok cycle; unstrobed bytes unchanged.
- Read returns the whole word regardless of size: rdata = mem[latched index] during data_ok, 0 otherwise.
- Memory array is not cleared by rst; only control state resets.

## Timing
- Reset values: addr_ok=0, data_ok=0, rdata=0, state=IDLE, counters 0.
- req rising in cycle C (IDLE, req low in C-1): addr_ok high in cycle C+ADDR_WAIT.
- Handshake in cycle H: data_ok high exactly in cycle H+LAT, for one cycle.
- Single outstanding: earliest next addr_ok is cycle H+LAT+1; with ADDR_WAIT=0, LAT=1, peak throughput is one transaction per 2 cycles.
- Read after write to same word always sees committed data (write commits before next accept).
- req dropped before addr_ok: no transaction; counter restarts on next req.
- Inputs ignored while BUSY; changes to addr/wdata after handshake have no effect.
- rst mid-transaction: return to IDLE next edge, no data_ok, pending write discarded, memory untouched.
- rst and handshake in same cycle: rst wins, nothing latched.

## Test plan
- Reset: hold rst 3 cycles with req=1 -> addr_ok, data_ok, rdata all 0; first addr_ok 1 cycle after rst release (ADDR_WAIT=1).
- Word write 0x00000010 <- 0x11223344, then read 0x10 -> handshake-to-data_ok = 2 cycles each; rdata=0x11223344 only in data_ok cycle.
- Byte write size 0 addr 0x13 wdata 0xAA000000, then halfword write addr 0x10 wdata 0x0000BEEF -> read 0x10 returns 0xAA22BEEF.
- ADDR_WAIT=3: req held -> addr_ok in 4th cycle; req dropped after 2 cycles then reasserted -> addr_ok again needs 3 further held cycles.
- Reset mid-op: write 0x0 <- 0xFFFFFFFF accepted, rst 1 cycle after handshake -> no data_ok; read 0x0 returns prior value.
- Aliasing and back-to-back: ADDR_WIDTH=12, ADDR_WAIT=0, LAT=1; write 0x00004000 <- 0xCAFEF00D then read 0x00000000 -> 0xCAFEF00D; accepts spaced exactly 2 cycles.
